oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA engine sitting between the 6502 core and the system bus. It snoops CPU writes to the DMA trigger register, halts the CPU, and takes over the bus. It then copies 256 bytes from the selected CPU page to the PPU OAM data port, using alternating read/write cycles. Cycle alignment matches NES behaviour: 513 or 514 halted cycles per transfer.

## Interface
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers a transfer
- `OAM_DATA_ADDR`, 16'h2004, bus address written with each copied byte
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cpu_addr`  in  16  CPU address for the current cycle
- `cpu_d_out`  in  8  CPU write data
- `cpu_we`  in  1  CPU write strobe for the current cycle
- `bus_d_in`  in  8  bus read data; combinational read, valid at the end of the cycle the address is driven
- `dma_active`  out  1  bus mux select; 1 = bus takes `dma_addr`/`dma_d_out`/`dma_we`
- `cpu_halt`  out  1  CPU must hold PC, IR, state and registers while high
- `dma_addr`  out  16  DMA bus address
- `dma_d_out`  out  8  DMA bus write data
- `dma_we`  out  1  DMA bus write strobe
- `dma_done`  out  1  high during the final WRITE cycle only

## Operation
- Parity flop `par`: reset 0, toggles every cycle; the first cycle after reset release has `par`=0 (even).
- Registers:
  - `page[7:0]`: source page
  - `idx[7:0]`: byte index
  - `data[7:0]`: read latch
  - all reset to 0
- States: IDLE, HALT, ALIGN, READ, WRITE; reset state IDLE.
- IDLE:
  - `cpu_we && cpu_addr==DMA_REG_ADDR` latches `page<=cpu_d_out` and `idx<=0`, then goes to HALT.
  - Otherwise stays in IDLE.
- HALT, one cycle:
  - Dummy read: `dma_addr={page,8'h00}`, `dma_we`=0.
  - If `par`=0 in this cycle, go to ALIGN; if `par`=1, go to READ.
  - Net effect: READ always lands on an even cycle.
- ALIGN, one cycle: same dummy read as HALT, then go to READ.
- READ:
  - `dma_addr={page,idx}`, `dma_we`=0.
  - Latches `data<=bus_d_in` at the cycle end.
  - Always goes to WRITE.
- WRITE:
  - `dma_addr=OAM_DATA_ADDR`, `dma_d_out=data`, `dma_we`=1, `idx<=idx+1` (8-bit wrap).
  - If `idx`==8'hFF, assert `dma_done` and go to IDLE; otherwise go to READ.
- Outputs:
  - `cpu_halt` = `dma_active` = (state != IDLE).
  - In IDLE, `dma_addr`=0, `dma_d_out`=0, `dma_we`=0.
  - `dma_d_out`=`data` in every non-IDLE state; it is only meaningful in WRITE.
- The page never crosses: the address high byte stays `page` for all 256 reads. `idx` wrap to 0 coincides with the return to IDLE.
- Trigger decode happens only in IDLE. Writes to `DMA_REG_ADDR` in any other state are ignored, including a write coincident with the final WRITE cycle.
- A CPU write to `OAM_DATA_ADDR` while IDLE is not intercepted; the bus handles it normally.
- Reset asserted mid-transfer aborts immediately:
  - All outputs go to 0 asynchronously and state returns to IDLE.
  - No further bus writes occur and there is no resume.

## Timing
- Trigger write is cycle 0; the CPU write completes normally in cycle 0.
- `cpu_halt`/`dma_active` rise at the start of cycle 1, in HALT.
- `par`=1 in HALT: READ in cycles 2,4,…,512; WRITE in cycles 3,5,…,513; 513 halted cycles.
- `par`=0 in HALT: ALIGN in cycle 2; READ in cycles 3,…,513; WRITE in cycles 4,…,514; 514 halted cycles.
- Byte n is read in cycle R and written to OAM in cycle R+1; it never needs more than one cycle of latch latency.
- `cpu_halt` falls the cycle after the last WRITE, and the CPU resumes then.
- A new trigger is accepted in that same first IDLE cycle.
- All outputs are registered-state decodes with no combinational path from `cpu_*` inputs to outputs. The exception is the IDLE→HALT transition, which takes effect next cycle.

## Test plan
- Reset values: hold `rst`=0 with random inputs -> all outputs 0. Release -> state IDLE, `cpu_halt`=0.
- Odd-aligned copy:
  - Stimulus: memory page 0x02 preloaded with 0x00..0xFF; write 0x02 to 0x4014 so that HALT has `par`=1.
  - Required: exactly 513 halted cycles.
  - Required: 256 writes to 0x2004 carrying 0x00..0xFF in order; first READ address 0x0200, last 0x02FF.
  - Required: `dma_done` high only on the final write.
- Even-aligned copy: same copy with HALT on `par`=0 -> one ALIGN cycle, 514 halted cycles, same data sequence.
- Ignored triggers:
  - A write to 0x4014 injected during READ/WRITE, and one on the last WRITE cycle -> no restart and `page` unchanged.
  - A write with 0x4015 -> no transfer.
- Reset mid-transfer: assert `rst`=0 after 100 writes -> outputs 0 immediately. After release, no further 0x2004 writes; a new trigger with page 0x07 copies from 0x0700.
- Back-to-back: trigger page 0x03 in the first IDLE cycle after a completed transfer -> accepted, with `cpu_halt` low for exactly one cycle between transfers.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to the trigger register, halts the CPU and copies
// one 256-byte page to the OAM data port with alternating read/write bus cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    input  logic [7:0]  bus_d_in,
    output logic        dma_active,
    output logic        cpu_halt,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_d_out,
    output logic        dma_we,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       par_reg;
    logic [7:0] page_reg;
    logic [7:0] page_next;
    logic [7:0] idx_reg;
    logic [7:0] idx_next;
    logic [7:0] data_reg;
    logic [7:0] data_next;
    logic       trigger;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    page_next  = cpu_d_out;
                    idx_next   = 8'h00;
                    state_next = HALT;
                end
            end
            // An odd HALT cycle goes straight to READ so reads always land on even cycles.
            HALT:  state_next = par_reg ? READ : ALIGN;
            ALIGN: state_next = READ;
            READ: begin
                data_next  = bus_d_in;
                state_next = WRITE;
            end
            WRITE: begin
                idx_next   = idx_reg + 8'd1;
                state_next = (idx_reg == 8'hFF) ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so they sit in flops and carry
    // no combinational path from the CPU inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            par_reg    <= 1'b0;
            page_reg   <= 8'h00;
            idx_reg    <= 8'h00;
            data_reg   <= 8'h00;
            dma_active <= 1'b0;
            cpu_halt   <= 1'b0;
            dma_addr   <= 16'h0000;
            dma_d_out  <= 8'h00;
            dma_we     <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            par_reg    <= ~par_reg;
            page_reg   <= page_next;
            idx_reg    <= idx_next;
            data_reg   <= data_next;
            dma_active <= (state_next != IDLE);
            cpu_halt   <= (state_next != IDLE);
            dma_we     <= (state_next == WRITE);
            dma_done   <= (state_next == WRITE) && (idx_next == 8'hFF);
            dma_d_out  <= (state_next == IDLE) ? 8'h00 : data_next;
            case (state_next)
                IDLE:    dma_addr <= 16'h0000;
                READ:    dma_addr <= {page_next, idx_next};
                WRITE:   dma_addr <= OAM_DATA_ADDR;
                default: dma_addr <= {page_next, 8'h00};
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues the expected OAM writes and halt
// lengths, a negedge monitor pops and compares them as the DUT produces them.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_d_out = 8'h0;
    logic        cpu_we = 1'b0;
    logic [7:0]  bus_d_in;
    logic        dma_active;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic [7:0]  dma_d_out;
    logic        dma_we;
    logic        dma_done;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .bus_d_in  (bus_d_in),
        .dma_active(dma_active),
        .cpu_halt  (cpu_halt),
        .dma_addr  (dma_addr),
        .dma_d_out (dma_d_out),
        .dma_we    (dma_we),
        .dma_done  (dma_done)
    );

    always #5 clk = ~clk;

    // Memory image: page 0x02 holds 0x00..0xFF, each later page is offset by 0x10.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [7:0] hi;
        hi = a[15:8] - 8'd2;
        return a[7:0] + {hi[3:0], 4'h0};
    endfunction

    assign bus_d_in = mem_val(dma_addr);

    typedef struct {
        logic [15:0] raddr;
        logic [7:0]  data;
        logic        done;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_halt[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  wr_seen = 0;
    logic tb_par = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor
    int          halt_cnt = 0;
    logic        prev_halt = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    always @(negedge clk) begin
        wr_t e;
        int  h;
        if (!rst) begin
            halt_cnt  = 0;
            prev_halt = 1'b0;
            prev_addr = 16'h0;
        end else begin
            if (cpu_halt !== dma_active) check("halt_eq_active", {31'd0, cpu_halt}, {31'd0, dma_active});
            if (dma_we) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {16'd0, dma_addr}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", {16'd0, dma_addr}, 32'h2004);
                    check("wr_data", {24'd0, dma_d_out}, {24'd0, e.data});
                    check("rd_addr", {16'd0, prev_addr}, {16'd0, e.raddr});
                    check("wr_done", {31'd0, dma_done}, {31'd0, e.done});
                end
            end else if (dma_done) begin
                check("done_without_we", {31'd0, dma_done}, 32'd0);
            end
            if (cpu_halt) begin
                halt_cnt++;
            end else if (prev_halt) begin
                if (exp_halt.size() == 0) begin
                    check("unexpected_halt", halt_cnt, 0);
                end else begin
                    h = exp_halt.pop_front();
                    check("halt_cycles", halt_cnt, h);
                    $display("transfer complete: %0d halted cycles (expected %0d)", halt_cnt, h);
                end
                halt_cnt = 0;
            end
            prev_halt = cpu_halt;
            prev_addr = dma_addr;
        end
    end

    function automatic logic [31:0] outs();
        return {dma_active, cpu_halt, dma_we, dma_done, dma_d_out, dma_addr};
    endfunction

    // Called at #1 after a posedge. want_halt_par: 0/1 forces HALT parity, -1 = now.
    task automatic trigger(input logic [15:0] a, input logic [7:0] pg, input int want_halt_par);
        wr_t e;
        if (want_halt_par >= 0 && int'(tb_par) == want_halt_par) begin
            @(posedge clk); #1;
        end
        cpu_addr  = a;
        cpu_d_out = pg;
        cpu_we    = 1'b1;
        if (a == 16'h4014) begin
            for (int i = 0; i < 256; i++) begin
                e.raddr = {pg, i[7:0]};
                e.data  = mem_val({pg, i[7:0]});
                e.done  = (i == 255);
                exp_wr.push_back(e);
            end
            // HALT falls in the next cycle: odd HALT -> 513 cycles, even HALT -> 514.
            exp_halt.push_back(tb_par ? 514 : 513);
        end
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_wr.size() == 0 && exp_halt.size() == 0) break;
            @(posedge clk); #1;
        end
        check("wait_idle_pending", exp_wr.size() + exp_halt.size(), 0);
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (dma_done) break;
            @(posedge clk); #1;
        end
        check("wait_done_seen", {31'd0, dma_done}, 32'd1);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_d_out = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h0000;
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            cpu_addr  = 16'($urandom);
            cpu_d_out = 8'($urandom);
            cpu_we    = 1'($urandom);
            @(posedge clk); #1;
            check("reset_outputs", outs(), 32'd0);
        end
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("post_reset_idle", outs(), 32'd0);

        // Odd-aligned copy (HALT par=1)
        trigger(16'h4014, 8'h02, 1);
        wait_idle(1200);

        // Even-aligned copy (HALT par=0)
        trigger(16'h4014, 8'h02, 0);
        wait_idle(1200);

        // Triggers while busy are ignored, including on the final WRITE
        trigger(16'h4014, 8'h02, -1);
        repeat (20) begin @(posedge clk); #1; end
        cpu_write(16'h4014, 8'h55);
        cpu_write(16'h4014, 8'h55);
        wait_done(1200);
        cpu_write(16'h4014, 8'h66);
        wait_idle(1200);
        repeat (8) begin @(posedge clk); #1; end
        check("no_restart", {31'd0, cpu_halt}, 32'd0);

        // Neighbouring address and OAM data writes in IDLE do not start a transfer
        cpu_write(16'h4015, 8'h02);
        repeat (8) begin @(posedge clk); #1; end
        check("no_xfer_4015", {31'd0, cpu_halt}, 32'd0);
        cpu_write(16'h2004, 8'hA5);
        @(posedge clk); #1;
        check("no_intercept_2004", {31'd0, dma_active}, 32'd0);

        // Reset mid-transfer after 100 writes
        begin
            int target;
            target = wr_seen + 100;
            trigger(16'h4014, 8'h02, -1);
            for (int c = 0; c < 600; c++) begin
                if (wr_seen >= target) break;
                @(posedge clk); #1;
            end
            check("reach_100_writes", wr_seen, target);
        end
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 32'd0);
        exp_wr.delete();
        exp_halt.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("no_resume", {31'd0, cpu_halt}, 32'd0);
        trigger(16'h4014, 8'h07, -1);
        wait_idle(1200);

        // Back-to-back: retrigger in the first IDLE cycle
        trigger(16'h4014, 8'h02, -1);
        wait_done(1200);
        @(posedge clk); #1;
        check("gap_halt_low", {31'd0, cpu_halt}, 32'd0);
        trigger(16'h4014, 8'h03, -1);
        check("gap_one_cycle", {31'd0, cpu_halt}, 32'd1);
        wait_idle(1200);
        repeat (4) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
